// File: rtl/nibble_addsub_pkg.sv
// Shared definitions for the nibble-serial add/sub controller.
//   NIBBLE_W : width of the shared add/sub slice
//   ST_*     : controller state encodings (2-bit)
package nibble_addsub_pkg;
  localparam int NIBBLE_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;
endpackage

// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Request/result bus of the nibble-serial add/sub controller.
//   Request : in_valid/in_ready with operands a, b and op select sub.
//   Result  : out_valid/out_ready with res and flags neg, cout, ovf, zero.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; the sender holds its payload stable until that edge, and
// ready is allowed to depend on nothing but the receiver's own state.
// Modports: master = requester/consumer side, slave = controller side.
interface nibble_serial_addsub_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int WIDTH = 4 * NIBBLES;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             neg;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, res, neg, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, res, neg, cout, ovf, zero
  );
endinterface

// File: rtl/nibble_addsub_slice.sv
// Combinational 4-bit ripple-carry adder, the single shared datapath slice.
//   a, b, cin : addends and carry in
//   s         : sum nibble
//   cout      : carry out of bit 3
//   c3        : carry into bit 3 (used for signed overflow)
module nibble_addsub_slice
  import nibble_addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                c3
);
  logic [NIBBLE_W:0] c;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[NIBBLE_W];
  assign c3   = c[NIBBLE_W-1];
endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract sequencer around one 4-bit slice.
// Pass 1 (RUN) computes A+B or A+~B+1 one nibble per clock, LSB first.
// A borrowing subtract takes a second pass (FIX) that two's-complements the
// raw result on the same slice, giving magnitude plus neg.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request/result interface (slave side)
//   dbg_state  : current FSM state
module nibble_serial_addsub_ctrl
  import nibble_addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  nibble_serial_addsub_ctrl_if.slave bus,
  output state_t dbg_state
);
  localparam int WIDTH = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             neg_q, neg_d, cout_q, cout_d;
  logic             ovf_q, ovf_d, zero_q, zero_d;

  logic [NIBBLE_W-1:0] sl_a, sl_b, sl_s;
  logic                sl_cout, sl_c3;
  logic [IDX_W+1:0]    bit_base;

  assign bit_base = {idx_q, 2'b00};

  // FIX negates the raw result: ~res + 1, carry-in seeded with 1.
  always_comb begin
    if (state_q == ST_FIX) begin
      sl_a = ~res_q[bit_base +: NIBBLE_W];
      sl_b = '0;
    end else begin
      sl_a = a_q[bit_base +: NIBBLE_W];
      sl_b = b_q[bit_base +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
    end
  end

  nibble_addsub_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (c_q),
    .s    (sl_s),
    .cout (sl_cout),
    .c3   (sl_c3)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    res_d   = res_q;
    neg_d   = neg_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          idx_d   = '0;
          c_d     = bus.sub;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[bit_base +: NIBBLE_W] = sl_s;
        c_d   = sl_cout;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d = sl_cout;
          ovf_d  = sl_c3 ^ sl_cout;
          idx_d  = '0;
          if (sub_q && !sl_cout) begin
            c_d     = 1'b1;
            state_d = ST_FIX;
          end else begin
            neg_d   = 1'b0;
            zero_d  = (res_d == '0);
            state_d = ST_DONE;
          end
        end
      end
      ST_FIX: begin
        // Carry out of the top nibble is dropped: magnitude fits in WIDTH.
        res_d[bit_base +: NIBBLE_W] = sl_s;
        c_d   = sl_cout;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          neg_d   = 1'b1;
          zero_d  = (res_d == '0);
          state_d = ST_DONE;
        end
      end
      default: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.res       = res_q;
  assign bus.neg       = neg_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed self-checking bench for nibble_serial_addsub_ctrl (NIBBLES=4).
module tb_nibble_serial_addsub_ctrl;
  import nibble_addsub_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     checks;
  int     errors;
  int     lat;
  logic [15:0] held_res;

  nibble_serial_addsub_ctrl_if #(.NIBBLES(4)) bus ();

  nibble_serial_addsub_ctrl #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and let it be accepted on the next edge; afterwards
  // scribble the operand pins to show they are no longer looked at.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic s);
    bus.a        = av;
    bus.b        = bv;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    chk("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom_range(0, 65535));
    bus.b        = 16'($urandom_range(0, 65535));
    bus.sub      = 1'($urandom_range(0, 1));
  endtask

  // Count edges from accept to out_valid, bounded.
  task automatic wait_done(input string tag, input int exp_lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic check_result(input string tag, input logic [15:0] r, input logic n,
                              input logic co, input logic ov, input logic z);
    chk({tag, "_res"},  {16'd0, bus.res}, {16'd0, r});
    chk({tag, "_flags"}, {28'd0, bus.neg, bus.cout, bus.ovf, bus.zero},
                         {28'd0, n, co, ov, z});
    chk({tag, "_in_ready_busy"}, {31'd0, bus.in_ready}, 32'd0);
  endtask

  task automatic finish_op(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_in_ready_back"},  {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_state"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, "_res_flags"}, {12'd0, bus.res, bus.neg, bus.cout, bus.ovf, bus.zero}, 32'd0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_state("reset");

    // basic add
    start_op(16'h1234, 16'h0FFF, 1'b0);
    wait_done("add1", 4);
    check_result("add1", 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0);
    finish_op("add1");

    // sub without borrow
    start_op(16'h5000, 16'h1234, 1'b1);
    wait_done("sub1", 4);
    check_result("sub1", 16'h3DCC, 1'b0, 1'b1, 1'b0, 1'b0);
    finish_op("sub1");

    // sub with borrow: goes through FIX
    start_op(16'h0003, 16'h0005, 1'b1);
    wait_done("sub2", 8);
    check_result("sub2", 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
    finish_op("sub2");

    // boundaries
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done("add_wrap", 4);
    check_result("add_wrap", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    finish_op("add_wrap");

    start_op(16'h7FFF, 16'h0001, 1'b0);
    wait_done("add_ovf", 4);
    check_result("add_ovf", 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
    finish_op("add_ovf");

    start_op(16'h1234, 16'h1234, 1'b1);
    wait_done("sub_eq", 4);
    check_result("sub_eq", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    finish_op("sub_eq");

    // large borrowing sub: 0x0001 - 0xFFFF -> |diff| = 0xFFFE, raw carry 0,
    // signed 1 - (-1) = 2 does not overflow
    start_op(16'h0001, 16'hFFFF, 1'b1);
    wait_done("sub_big", 8);
    check_result("sub_big", 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
    finish_op("sub_big");

    // backpressure: result held with a competing request pending
    start_op(16'h00FF, 16'h0001, 1'b0);
    wait_done("bp", 4);
    held_res     = 16'h0100;
    bus.a        = 16'h0100;
    bus.b        = 16'h0010;
    bus.sub      = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {12'd0, bus.res, bus.out_valid, bus.in_ready, bus.neg, bus.zero},
                     {12'd0, held_res, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    finish_op("bp");
    // in_valid still high: accepted on this edge
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_next_accept", {30'd0, dbg_state}, {30'd0, ST_RUN});
    wait_done("bp_next", 4);
    check_result("bp_next", 16'h00F0, 1'b0, 1'b1, 1'b0, 1'b0);
    finish_op("bp_next");

    // reset mid-RUN at idx=2
    start_op(16'h1111, 16'h2222, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_state("rst_run");

    // reset mid-FIX
    start_op(16'h0003, 16'h0005, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_fix_in_fix", {30'd0, dbg_state}, {30'd0, ST_FIX});
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_state("rst_fix");

    // fresh add after reset
    start_op(16'h0A0B, 16'h0101, 1'b0);
    wait_done("post_rst", 4);
    check_result("post_rst", 16'h0B0C, 1'b0, 1'b0, 1'b0, 1'b0);
    finish_op("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
